wordcount_dma_seq: RTL

Sequencer between the wordcount host-control interface and the AXI read/write master pair. On kick it latches the scalar parameters and splits the input region into bounded read chunks, issuing one reader start per chunk. It optionally flushes the counting core, then issues one writer transfer for the result table. It owns busy and done, so the top level only instantiates it between the control registers and the masters.

---
 rtl/wordcount_pkg.sv | 18 +
 rtl/wordcount_chunker.sv | 41 ++++
 rtl/wordcount_dma_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/wordcount_pkg.sv
// wordcount_pkg: command encodings, sequencer states and sizing defaults shared by the wordcount blocks
package wordcount_pkg;
    localparam int WORD_BYTES  = 64;
    localparam int CHUNK_WORDS = 256;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_RW    = 2'd3;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_FLUSH,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_DONE,
        S_ERR
    } state_t;
endpackage

// File: rtl/wordcount_chunker.sv
// wordcount_chunker: walks the input region in reader transfers of at most CHUNK_WORDS words
//   load/base/num_of_words : restart the walk at base with num_of_words remaining
//   adv                    : current chunk completed, step past it
//   addr/size              : byte address and byte size of the current chunk
//   last                   : current chunk exhausts the region
module wordcount_chunker #(
    parameter int ADDR_W      = 64,
    parameter int CNT_W       = 32,
    parameter int WORD_BYTES  = wordcount_pkg::WORD_BYTES,
    parameter int CHUNK_WORDS = wordcount_pkg::CHUNK_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  num_of_words,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] size,
    output logic              last
);
    localparam int SHIFT = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0] MAX_CHUNK = CNT_W'(CHUNK_WORDS);
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] chunk;
    assign chunk = (remaining < MAX_CHUNK) ? remaining : MAX_CHUNK;
    assign size  = ADDR_W'(chunk) << SHIFT;
    assign last  = remaining <= MAX_CHUNK;
    always_ff @(posedge clk) begin
        if (!reset) begin
            remaining <= '0;
            addr      <= '0;
        end else if (load) begin
            remaining <= num_of_words;
            addr      <= base;
        end else if (adv) begin
            remaining <= remaining - chunk;
            addr      <= addr + size;
        end
    end
endmodule

// File: rtl/wordcount_dma_seq.sv
// wordcount_dma_seq: sequences chunked reads, core flush and the result write for one host command
//   clk/reset                        : clock, synchronous active-low reset
//   kick/command/num_of_words/...    : host command, accepted only when idle
//   busy/done/error                  : host status (done/error are one-cycle pulses)
//   reader_ctrl_*                    : read master start/done and chunk address/size
//   writer_ctrl_*                    : write master start/done and result address/size
//   core_flush/core_flush_done       : drain handshake with the counting core
module wordcount_dma_seq #(
    parameter int ADDR_W      = 64,
    parameter int WORD_BYTES  = wordcount_pkg::WORD_BYTES,
    parameter int CHUNK_WORDS = wordcount_pkg::CHUNK_WORDS,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              kick,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic [31:0]       command,
    input  logic [CNT_W-1:0]  num_of_words,
    input  logic [CNT_W-1:0]  result_words,
    input  logic [ADDR_W-1:0] global_memory_offset,
    output logic              reader_ctrl_start,
    input  logic              reader_ctrl_done,
    output logic [ADDR_W-1:0] reader_ctrl_addr_offset,
    output logic [ADDR_W-1:0] reader_ctrl_xfer_size_in_bytes,
    output logic              writer_ctrl_start,
    input  logic              writer_ctrl_done,
    output logic [ADDR_W-1:0] writer_ctrl_addr_offset,
    output logic [ADDR_W-1:0] writer_ctrl_xfer_size_in_bytes,
    output logic              core_flush,
    input  logic              core_flush_done
);
    import wordcount_pkg::*;
    localparam int SHIFT = $clog2(WORD_BYTES);
    state_t            state, nxt;
    logic [1:0]        cmd_q;
    logic [CNT_W-1:0]  num_q, res_q;
    logic [ADDR_W-1:0] off_q;
    logic              flush_seen;
    logic              accept, legal, rd_adv, rd_last;
    assign accept = (state == S_IDLE) && kick;
    assign legal  = (command >= 32'd1) && (command <= 32'd3);
    assign rd_adv = (state == S_RD_WAIT) && reader_ctrl_done;
    wordcount_chunker #(
        .ADDR_W(ADDR_W),
        .CNT_W(CNT_W),
        .WORD_BYTES(WORD_BYTES),
        .CHUNK_WORDS(CHUNK_WORDS)
    ) u_chunker (
        .clk(clk),
        .reset(reset),
        .load(accept),
        .base(global_memory_offset),
        .num_of_words(num_of_words),
        .adv(rd_adv),
        .addr(reader_ctrl_addr_offset),
        .size(reader_ctrl_xfer_size_in_bytes),
        .last(rd_last)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cmd_q      <= '0;
            num_q      <= '0;
            res_q      <= '0;
            off_q      <= '0;
            flush_seen <= 1'b0;
        end else begin
            state      <= nxt;
            flush_seen <= (state == S_FLUSH);
            if (accept) begin
                cmd_q <= command[1:0];
                num_q <= num_of_words;
                res_q <= result_words;
                off_q <= global_memory_offset;
            end
        end
    end
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:
                if (kick)
                    nxt = !legal                          ? S_ERR :
                          (command[1:0] == CMD_WRITE)     ? S_FLUSH :
                          (num_of_words != '0)            ? S_RD_ISSUE :
                          (command[1:0] == CMD_RW)        ? S_FLUSH : S_DONE;
            S_RD_ISSUE: nxt = S_RD_WAIT;
            S_RD_WAIT:
                if (reader_ctrl_done)
                    nxt = !rd_last ? S_RD_ISSUE : (cmd_q == CMD_RW) ? S_FLUSH : S_DONE;
            S_FLUSH:
                if (core_flush_done)
                    nxt = (res_q == '0) ? S_DONE : S_WR_ISSUE;
            S_WR_ISSUE: nxt = S_WR_WAIT;
            S_WR_WAIT:  nxt = writer_ctrl_done ? S_DONE : S_WR_WAIT;
            default:    nxt = S_IDLE;
        endcase
    end
    assign busy              = state != S_IDLE;
    assign done              = state == S_DONE;
    assign error             = state == S_ERR;
    assign reader_ctrl_start = state == S_RD_ISSUE;
    assign writer_ctrl_start = state == S_WR_ISSUE;
    // flush_seen lags the state by a cycle, so only the first FLUSH cycle pulses
    assign core_flush        = (state == S_FLUSH) && !flush_seen;
    assign writer_ctrl_addr_offset        = off_q + (ADDR_W'(num_q) << SHIFT);
    assign writer_ctrl_xfer_size_in_bytes = ADDR_W'(res_q) << SHIFT;
endmodule
